// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: the decoded control bundle
// and the register-index width used across stage boundaries.
package pipeline_pkg;

    localparam int REG_IDX_W = 5;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic [3:0] alu_control;
        logic       alu_src;
        logic [2:0] width_src;
        logic [1:0] pad;
    } ctrl_t;

    localparam int CTRL_BITS = $bits(ctrl_t);

    localparam int REG_WRITE_BIT  = 15;
    localparam int RESULT_SRC_LSB = 13;
    localparam int MEM_WRITE_BIT  = 12;
    localparam int JUMP_BIT       = 11;
    localparam int BRANCH_BIT     = 10;
    localparam int ALU_CTRL_LSB   = 6;
    localparam int ALU_SRC_BIT    = 5;
    localparam int WIDTH_SRC_LSB  = 2;
    localparam int PAD_LSB        = 0;

    // All-zero control word: no register or memory write.
    function automatic ctrl_t bubble_ctrl();
        return '0;
    endfunction

endpackage

// File: rtl/pipe_reg.sv
// Generic W-bit pipeline flop with load enable and
// synchronous clear; clear has priority over load.
module pipe_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Reset, then clear, then load; otherwise hold.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/id_ex_reg.sv
// Decode->Execute pipeline register with stall hold,
// flush bubble insertion and a saturating bubble counter.
module id_ex_reg
    import pipeline_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int CTRL_W = CTRL_BITS,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 stall_e,
    input  logic                 flush_e,
    input  logic                 valid_d,
    input  logic [CTRL_W-1:0]    ctrl_d,
    input  logic [XLEN-1:0]      rd1_d,
    input  logic [XLEN-1:0]      rd2_d,
    input  logic [REG_IDX_W-1:0] rs1_d,
    input  logic [REG_IDX_W-1:0] rs2_d,
    input  logic [REG_IDX_W-1:0] rd_d,
    input  logic [XLEN-1:0]      imm_d,
    input  logic [XLEN-1:0]      pc_d,
    input  logic [XLEN-1:0]      pc_plus4_d,
    output logic                 valid_e,
    output logic [CTRL_W-1:0]    ctrl_e,
    output logic [XLEN-1:0]      rd1_e,
    output logic [XLEN-1:0]      rd2_e,
    output logic [REG_IDX_W-1:0] rs1_e,
    output logic [REG_IDX_W-1:0] rs2_e,
    output logic [REG_IDX_W-1:0] rd_e,
    output logic [XLEN-1:0]      imm_e,
    output logic [XLEN-1:0]      pc_e,
    output logic [XLEN-1:0]      pc_plus4_e,
    output logic [CNT_W-1:0]     bubble_cnt
);

    localparam int IDX_W  = 3 * REG_IDX_W;
    localparam int DATA_W = 3 * XLEN;
    localparam int PC_W   = 2 * XLEN;

    logic load;
    logic cnt_max;

    assign load    = ~stall_e;
    assign cnt_max = (bubble_cnt == {CNT_W{1'b1}});

    pipe_reg #(.W(1)) u_valid (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (load),
        .clr     (flush_e),
        .d       (valid_d),
        .q       (valid_e)
    );

    pipe_reg #(.W(CTRL_W)) u_ctrl (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (load),
        .clr     (flush_e),
        .d       (ctrl_d),
        .q       (ctrl_e)
    );

    pipe_reg #(.W(IDX_W)) u_idx (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (load),
        .clr     (flush_e),
        .d       ({rs1_d, rs2_d, rd_d}),
        .q       ({rs1_e, rs2_e, rd_e})
    );

    pipe_reg #(.W(DATA_W)) u_data (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (load),
        .clr     (flush_e),
        .d       ({rd1_d, rd2_d, imm_d}),
        .q       ({rd1_e, rd2_e, imm_e})
    );

    pipe_reg #(.W(PC_W)) u_pc (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (load),
        .clr     (flush_e),
        .d       ({pc_d, pc_plus4_d}),
        .q       ({pc_e, pc_plus4_e})
    );

    // Count inserted bubbles, sticking at all-ones.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bubble_cnt <= '0;
        end else if (flush_e && !cnt_max) begin
            bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg: table-driven vectors
// plus hand sequences, checked through an expectation queue.
module tb_id_ex_reg;

    logic        clk;
    logic        reset_n;
    logic        stall_e;
    logic        flush_e;
    logic        valid_d;
    logic [15:0] ctrl_d;
    logic [31:0] rd1_d;
    logic [31:0] rd2_d;
    logic [4:0]  rs1_d;
    logic [4:0]  rs2_d;
    logic [4:0]  rd_d;
    logic [31:0] imm_d;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4_d;
    logic        valid_e;
    logic [15:0] ctrl_e;
    logic [31:0] rd1_e;
    logic [31:0] rd2_e;
    logic [4:0]  rs1_e;
    logic [4:0]  rs2_e;
    logic [4:0]  rd_e;
    logic [31:0] imm_e;
    logic [31:0] pc_e;
    logic [31:0] pc_plus4_e;
    logic [3:0]  bubble_cnt;

    int total;
    int bad;

    typedef struct {
        logic        rst_n;
        logic        stall;
        logic        flush;
        logic        valid;
        logic [15:0] ctrl;
        logic [4:0]  rd;
        logic [31:0] rd1;
        logic        ev;
        logic [15:0] ectrl;
        logic [4:0]  erd;
        logic [31:0] erd1;
        logic [3:0]  ecnt;
    } vec_t;

    typedef struct {
        logic        v;
        logic [15:0] ctrl;
        logic [4:0]  rd;
        logic [31:0] rd1;
        logic [3:0]  cnt;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[15];

    id_ex_reg #(
        .XLEN   (32),
        .CTRL_W (16),
        .CNT_W  (4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .stall_e    (stall_e),
        .flush_e    (flush_e),
        .valid_d    (valid_d),
        .ctrl_d     (ctrl_d),
        .rd1_d      (rd1_d),
        .rd2_d      (rd2_d),
        .rs1_d      (rs1_d),
        .rs2_d      (rs2_d),
        .rd_d       (rd_d),
        .imm_d      (imm_d),
        .pc_d       (pc_d),
        .pc_plus4_d (pc_plus4_d),
        .valid_e    (valid_e),
        .ctrl_e     (ctrl_e),
        .rd1_e      (rd1_e),
        .rd2_e      (rd2_e),
        .rs1_e      (rs1_e),
        .rs2_e      (rs2_e),
        .rd_e       (rd_e),
        .imm_e      (imm_e),
        .pc_e       (pc_e),
        .pc_plus4_e (pc_plus4_e),
        .bubble_cnt (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Remaining data fields are fixed functions of rd1 (zero maps to zero).
    task automatic drive(input logic r, input logic s, input logic f,
                         input logic v, input logic [15:0] c,
                         input logic [4:0] rd, input logic [31:0] r1);
        reset_n    = r;
        stall_e    = s;
        flush_e    = f;
        valid_d    = v;
        ctrl_d     = c;
        rd_d       = rd;
        rd1_d      = r1;
        rd2_d      = r1 << 1;
        rs1_d      = r1[4:0];
        rs2_d      = r1[9:5];
        imm_d      = r1 * 3;
        pc_d       = r1 << 2;
        pc_plus4_d = r1 * 5;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic push(input logic v, input logic [15:0] c,
                        input logic [4:0] rd, input logic [31:0] r1,
                        input logic [3:0] cnt);
        exp_t e;
        e.v    = v;
        e.ctrl = c;
        e.rd   = rd;
        e.rd1  = r1;
        e.cnt  = cnt;
        sb.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: scoreboard empty", tag);
            return;
        end
        e = sb.pop_front();
        chk({tag, ".valid_e"},  32'(valid_e),    32'(e.v));
        chk({tag, ".ctrl_e"},   32'(ctrl_e),     32'(e.ctrl));
        chk({tag, ".rd_e"},     32'(rd_e),       32'(e.rd));
        chk({tag, ".rd1_e"},    rd1_e,           e.rd1);
        chk({tag, ".rd2_e"},    rd2_e,           e.rd1 << 1);
        chk({tag, ".rs1_e"},    32'(rs1_e),      32'(e.rd1[4:0]));
        chk({tag, ".rs2_e"},    32'(rs2_e),      32'(e.rd1[9:5]));
        chk({tag, ".imm_e"},    imm_e,           e.rd1 * 3);
        chk({tag, ".pc_e"},     pc_e,            e.rd1 << 2);
        chk({tag, ".pc4_e"},    pc_plus4_e,      e.rd1 * 5);
        chk({tag, ".bubbles"},  32'(bubble_cnt), 32'(e.cnt));
    endtask

    task automatic edge_check(input string tag);
        @(posedge clk);
        #1;
        pop_check(tag);
    endtask

    function automatic vec_t mk(logic r, logic s, logic f, logic v,
                                logic [15:0] c, logic [4:0] rd,
                                logic [31:0] r1, logic ev,
                                logic [15:0] ec, logic [4:0] erd,
                                logic [31:0] er1, logic [3:0] ecnt);
        vec_t t;
        t.rst_n = r;  t.stall = s;  t.flush = f;  t.valid = v;
        t.ctrl  = c;  t.rd    = rd; t.rd1   = r1;
        t.ev    = ev; t.ectrl = ec; t.erd   = erd;
        t.erd1  = er1; t.ecnt = ecnt;
        return t;
    endfunction

    initial begin
        total = 0;
        bad   = 0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 5'd0, 32'h0);

        //           rst stl fl  v  ctrl      rd     rd1            ev ectrl     erd    erd1           cnt
        vecs[0]  = mk(0, 0, 0, 1, 16'hFFFF, 5'd31, 32'hDEADBEEF, 0, 16'h0000, 5'd0,  32'h0,        4'd0);
        vecs[1]  = mk(1, 0, 0, 1, 16'h00A5, 5'd7,  32'h00000001, 1, 16'h00A5, 5'd7,  32'h00000001, 4'd0);
        vecs[2]  = mk(1, 0, 0, 1, 16'h1234, 5'd3,  32'h00000010, 1, 16'h1234, 5'd3,  32'h00000010, 4'd0);
        vecs[3]  = mk(1, 1, 0, 1, 16'h5555, 5'd9,  32'h00000020, 1, 16'h1234, 5'd3,  32'h00000010, 4'd0);
        vecs[4]  = mk(1, 1, 0, 1, 16'h5555, 5'd9,  32'h00000020, 1, 16'h1234, 5'd3,  32'h00000010, 4'd0);
        vecs[5]  = mk(1, 1, 0, 1, 16'h5555, 5'd9,  32'h00000020, 1, 16'h1234, 5'd3,  32'h00000010, 4'd0);
        vecs[6]  = mk(1, 0, 0, 1, 16'h5555, 5'd9,  32'h00000020, 1, 16'h5555, 5'd9,  32'h00000020, 4'd0);
        vecs[7]  = mk(1, 1, 1, 1, 16'hFFFF, 5'd17, 32'hCAFEF00D, 0, 16'h0000, 5'd0,  32'h0,        4'd1);
        vecs[8]  = mk(1, 0, 0, 0, 16'h0000, 5'd4,  32'hABCD1234, 0, 16'h0000, 5'd4,  32'hABCD1234, 4'd1);
        vecs[9]  = mk(1, 0, 0, 1, 16'h8001, 5'd12, 32'h00000077, 1, 16'h8001, 5'd12, 32'h00000077, 4'd1);
        vecs[10] = mk(1, 0, 1, 1, 16'h9009, 5'd21, 32'h12345678, 0, 16'h0000, 5'd0,  32'h0,        4'd2);
        vecs[11] = mk(1, 1, 0, 1, 16'h7777, 5'd8,  32'h00000099, 0, 16'h0000, 5'd0,  32'h0,        4'd2);
        vecs[12] = mk(1, 0, 0, 1, 16'hF00F, 5'd30, 32'hFFFFFFFF, 1, 16'hF00F, 5'd30, 32'hFFFFFFFF, 4'd2);
        vecs[13] = mk(0, 1, 0, 1, 16'h3C3C, 5'd6,  32'h0BADF00D, 0, 16'h0000, 5'd0,  32'h0,        4'd0);
        vecs[14] = mk(1, 0, 0, 1, 16'h0A0A, 5'd5,  32'h00000055, 1, 16'h0A0A, 5'd5,  32'h00000055, 4'd0);

        #1;
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].rst_n, vecs[i].stall, vecs[i].flush,
                  vecs[i].valid, vecs[i].ctrl, vecs[i].rd, vecs[i].rd1);
            push(vecs[i].ev, vecs[i].ectrl, vecs[i].erd,
                 vecs[i].erd1, vecs[i].ecnt);
            edge_check($sformatf("vec%0d", i));
        end

        // Twenty back-to-back flushes: counter climbs to 15 and sticks.
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, i[0], 1'b1, 1'b1, 16'hFFFF, 5'd31, 32'h100 + i);
            push(1'b0, 16'h0, 5'd0, 32'h0, (i >= 14) ? 4'd15 : 4'(i + 1));
            edge_check($sformatf("sat%0d", i));
        end

        // Reset during a flush wins and clears the counter.
        drive(1'b0, 1'b0, 1'b1, 1'b1, 16'h1111, 5'd1, 32'h2222);
        push(1'b0, 16'h0, 5'd0, 32'h0, 4'd0);
        edge_check("rst_flush");

        // Following edge obeys normal priority: one bubble counted.
        drive(1'b1, 1'b0, 1'b1, 1'b1, 16'h1111, 5'd1, 32'h2222);
        push(1'b0, 16'h0, 5'd0, 32'h0, 4'd1);
        edge_check("post_rst_flush");

        // Then a plain load.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 16'hE5E5, 5'd29, 32'h3C3C3C3C);
        push(1'b1, 16'hE5E5, 5'd29, 32'h3C3C3C3C, 4'd1);
        edge_check("final_load");

        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL leftover: got %0d want 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
